// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the subordinate RAM arbiter between the I2C
// memory engine and the local host port.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 7;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOCKED,
        FORCE_HOST
    } arb_state_t;

    typedef enum logic {
        OWN_I2C,
        OWN_HOST
    } owner_t;

endpackage

// File: rtl/mem_arb_lock_fsm.sv
// Round-robin / I2C-lock arbitration state machine with a bounded host
// starvation counter; produces the per-cycle winner select.
module mem_arb_lock_fsm
    import mem_arb_pkg::*;
#(
    parameter int LOCK_MAX = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i2c_req,
    input  logic i2c_lock,
    input  logic host_req,
    output logic sel_i2c,
    output logic sel_host
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    owner_t           last_owner_q, last_owner_d;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            last_owner_q <= OWN_HOST;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        last_owner_d = last_owner_q;
        sel_i2c      = 1'b0;
        sel_host     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i2c_req && (!host_req || last_owner_q == OWN_HOST)) begin
                    sel_i2c      = 1'b1;
                    last_owner_d = OWN_I2C;
                    if (i2c_lock) state_d = LOCKED;
                end else if (host_req) begin
                    sel_host     = 1'b1;
                    last_owner_d = OWN_HOST;
                end
            end
            LOCKED: begin
                sel_i2c = i2c_req;
                if (i2c_req) last_owner_d = OWN_I2C;
                // Starvation bound wins over a simultaneous lock release.
                if (host_req && starve_cnt_q == CNT_LAST) begin
                    state_d = FORCE_HOST;
                end else begin
                    if (host_req) starve_cnt_d = starve_cnt_q + 1'b1;
                    if (!i2c_lock) begin
                        state_d      = IDLE;
                        starve_cnt_d = '0;
                        last_owner_d = OWN_I2C;
                    end
                end
            end
            FORCE_HOST: begin
                sel_host     = host_req;
                if (host_req) last_owner_d = OWN_HOST;
                starve_cnt_d = '0;
                state_d      = i2c_lock ? LOCKED : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the single-port 128x8 RAM between the I2C memory engine and the
// host port: grant gating, RAM muxing and one-cycle read return.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int LOCK_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2c_req,
    input  logic              i2c_we,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    input  logic              i2c_lock,
    output logic              i2c_gnt,
    output logic              i2c_rvalid,
    output logic [DATA_W-1:0] i2c_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rddata
);

    logic              sel_i2c, sel_host;
    logic              rd_valid;
    owner_t            rd_owner;
    logic [DATA_W-1:0] i2c_rdata_q, host_rdata_q;

    mem_arb_lock_fsm #(.LOCK_MAX(LOCK_MAX)) u_lock_fsm (
        .clk      (clk),
        .rst      (rst),
        .i2c_req  (i2c_req),
        .i2c_lock (i2c_lock),
        .host_req (host_req),
        .sel_i2c  (sel_i2c),
        .sel_host (sel_host)
    );

    assign i2c_gnt  = sel_i2c  & i2c_req  & ~rst;
    assign host_gnt = sel_host & host_req & ~rst;

    always_comb begin
        mem_address = '0;
        mem_wrdata  = '0;
        mem_wren    = 1'b0;
        if (i2c_gnt) begin
            mem_address = i2c_addr;
            mem_wrdata  = i2c_wdata;
            mem_wren    = i2c_we;
        end else if (host_gnt) begin
            mem_address = host_addr;
            mem_wrdata  = host_wdata;
            mem_wren    = host_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid     <= 1'b0;
            rd_owner     <= OWN_HOST;
            i2c_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            rd_valid <= (i2c_gnt & ~i2c_we) | (host_gnt & ~host_we);
            rd_owner <= host_gnt ? OWN_HOST : OWN_I2C;
            if (i2c_rvalid)  i2c_rdata_q  <= mem_rddata;
            if (host_rvalid) host_rdata_q <= mem_rddata;
        end
    end

    // A read in flight when reset arrives is dropped, not delivered.
    assign i2c_rvalid  = rd_valid & (rd_owner == OWN_I2C)  & ~rst;
    assign host_rvalid = rd_valid & (rd_owner == OWN_HOST) & ~rst;
    assign i2c_rdata   = i2c_rvalid  ? mem_rddata : i2c_rdata_q;
    assign host_rdata  = host_rvalid ? mem_rddata : host_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter (LOCK_MAX=4) with a behavioural
// 128x8 synchronous-read RAM model.
module tb_mem_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       i2c_req, i2c_we, i2c_lock;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_wdata;
    logic       i2c_gnt, i2c_rvalid;
    logic [7:0] i2c_rdata;
    logic       host_req, host_we;
    logic [6:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic [6:0] mem_address;
    logic [7:0] mem_wrdata;
    logic       mem_wren;
    logic [7:0] mem_rddata;

    logic [7:0] ram [128];

    int checks = 0;
    int errors = 0;

    mem_access_arbiter #(.ADDR_W(7), .DATA_W(8), .LOCK_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i2c_req     (i2c_req),
        .i2c_we      (i2c_we),
        .i2c_addr    (i2c_addr),
        .i2c_wdata   (i2c_wdata),
        .i2c_lock    (i2c_lock),
        .i2c_gnt     (i2c_gnt),
        .i2c_rvalid  (i2c_rvalid),
        .i2c_rdata   (i2c_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_address (mem_address),
        .mem_wrdata  (mem_wrdata),
        .mem_wren    (mem_wren),
        .mem_rddata  (mem_rddata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_wrdata;
        mem_rddata <= ram[mem_address];
    end

    typedef struct {
        logic       rst;
        logic       ir, iw, il;
        logic [6:0] ia;
        logic [7:0] id;
        logic       hr, hw;
        logic [6:0] ha;
        logic [7:0] hd;
        logic       e_ig, e_hg, e_wren;
        logic [6:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_irv;
        logic [7:0] e_ird;
        logic       e_hrv;
        logic [7:0] e_hrd;
    } vec_t;

    function automatic vec_t mk(
        input logic r, ir, iw, il, input logic [6:0] ia, input logic [7:0] id,
        input logic hr, hw, input logic [6:0] ha, input logic [7:0] hd,
        input logic eig, ehg, ewr, input logic [6:0] ea, input logic [7:0] ewd,
        input logic eirv, input logic [7:0] eird, input logic ehrv, input logic [7:0] ehrd);
        vec_t v;
        v.rst = r; v.ir = ir; v.iw = iw; v.il = il; v.ia = ia; v.id = id;
        v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
        v.e_ig = eig; v.e_hg = ehg; v.e_wren = ewr; v.e_addr = ea; v.e_wdata = ewd;
        v.e_irv = eirv; v.e_ird = eird; v.e_hrv = ehrv; v.e_hrd = ehrd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Each character of gn is the expected winner: I, H or '-' for none.
    task automatic run_seq(input string tag, input string lk, input string gn);
        for (int i = 0; i < gn.len(); i++) begin
            i2c_lock = (lk.getc(i) == "1");
            @(negedge clk);
            check($sformatf("%s[%0d] i2c_gnt", tag, i), i2c_gnt, gn.getc(i) == "I");
            check($sformatf("%s[%0d] host_gnt", tag, i), host_gnt, gn.getc(i) == "H");
            check($sformatf("%s[%0d] mem_address", tag, i), mem_address,
                  gn.getc(i) == "I" ? 32'h10 : (gn.getc(i) == "H" ? 32'h20 : 32'h0));
            next_cycle();
        end
    endtask

    vec_t vecs [12];

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 8'h00;
        ram[7'h10] = 8'hA5;
        ram[7'h20] = 8'h5A;
        mem_rddata = 8'h00;

        rst = 1'b1;
        i2c_req = 0; i2c_we = 0; i2c_lock = 0; i2c_addr = '0; i2c_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;

        //          rst ir iw il ia     id     hr hw ha     hd   | ig hg wr addr   wdata  irv ird    hrv hrd
        vecs[0]  = mk(1, 1, 0, 0, 7'h10, 8'h00, 1, 0, 7'h20, 8'h00, 0, 0, 0, 7'h00, 8'h00, 0, 8'h00, 0, 8'h00);
        vecs[1]  = mk(1, 1, 0, 0, 7'h10, 8'h00, 1, 0, 7'h20, 8'h00, 0, 0, 0, 7'h00, 8'h00, 0, 8'h00, 0, 8'h00);
        vecs[2]  = mk(0, 1, 0, 0, 7'h10, 8'h00, 1, 0, 7'h20, 8'h00, 1, 0, 0, 7'h10, 8'h00, 0, 8'h00, 0, 8'h00);
        vecs[3]  = mk(0, 1, 0, 0, 7'h10, 8'h00, 1, 0, 7'h20, 8'h00, 0, 1, 0, 7'h20, 8'h00, 1, 8'hA5, 0, 8'h00);
        vecs[4]  = mk(0, 1, 0, 0, 7'h10, 8'h00, 1, 0, 7'h20, 8'h00, 1, 0, 0, 7'h10, 8'h00, 0, 8'hA5, 1, 8'h5A);
        vecs[5]  = mk(0, 1, 0, 0, 7'h10, 8'h00, 1, 0, 7'h20, 8'h00, 0, 1, 0, 7'h20, 8'h00, 1, 8'hA5, 0, 8'h5A);
        vecs[6]  = mk(0, 1, 1, 0, 7'h7F, 8'h3C, 0, 0, 7'h00, 8'h00, 1, 0, 1, 7'h7F, 8'h3C, 0, 8'hA5, 1, 8'h5A);
        vecs[7]  = mk(0, 0, 0, 0, 7'h00, 8'h00, 1, 0, 7'h7F, 8'h00, 0, 1, 0, 7'h7F, 8'h00, 0, 8'hA5, 0, 8'h5A);
        vecs[8]  = mk(0, 0, 0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 7'h00, 8'h00, 0, 8'hA5, 1, 8'h3C);
        vecs[9]  = mk(0, 0, 0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 7'h00, 8'h00, 0, 8'hA5, 0, 8'h3C);
        vecs[10] = mk(0, 0, 0, 1, 7'h00, 8'h00, 1, 0, 7'h10, 8'h00, 0, 1, 0, 7'h10, 8'h00, 0, 8'hA5, 0, 8'h3C);
        vecs[11] = mk(0, 0, 0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0, 7'h00, 8'h00, 0, 8'hA5, 1, 8'hA5);

        next_cycle();
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst;
            i2c_req = vecs[i].ir; i2c_we = vecs[i].iw; i2c_lock = vecs[i].il;
            i2c_addr = vecs[i].ia; i2c_wdata = vecs[i].id;
            host_req = vecs[i].hr; host_we = vecs[i].hw;
            host_addr = vecs[i].ha; host_wdata = vecs[i].hd;
            @(negedge clk);
            check($sformatf("v%0d i2c_gnt", i), i2c_gnt, vecs[i].e_ig);
            check($sformatf("v%0d host_gnt", i), host_gnt, vecs[i].e_hg);
            check($sformatf("v%0d mem_wren", i), mem_wren, vecs[i].e_wren);
            check($sformatf("v%0d mem_address", i), mem_address, vecs[i].e_addr);
            check($sformatf("v%0d mem_wrdata", i), mem_wrdata, vecs[i].e_wdata);
            check($sformatf("v%0d i2c_rvalid", i), i2c_rvalid, vecs[i].e_irv);
            check($sformatf("v%0d i2c_rdata", i), i2c_rdata, vecs[i].e_ird);
            check($sformatf("v%0d host_rvalid", i), host_rvalid, vecs[i].e_hrv);
            check($sformatf("v%0d host_rdata", i), host_rdata, vecs[i].e_hrd);
            next_cycle();
        end

        // Lock with LOCK_MAX=4: IDLE grant + 4 locked grants, then forced host slot.
        i2c_req = 1; i2c_we = 0; i2c_addr = 7'h10; i2c_wdata = '0;
        host_req = 1; host_we = 0; host_addr = 7'h20; host_wdata = '0;
        run_seq("lock", "1111111111111111", "IIIIIHIIIIHIIIIH");
        // Lock release while host waits: last locked I2C grant, then round-robin.
        run_seq("unlock", "000", "IHI");
        // Lock release in the same cycle the starvation bound trips.
        run_seq("drop_force", "11111000", "HIIIIIHI");

        // Reset arriving the cycle after a host read grant.
        i2c_req = 0; i2c_lock = 0;
        @(negedge clk);
        check("rstmid host_gnt", host_gnt, 1'b1);
        next_cycle();
        rst = 1; i2c_req = 1;
        @(negedge clk);
        check("rstmid host_rvalid", host_rvalid, 1'b0);
        check("rstmid i2c_gnt", i2c_gnt, 1'b0);
        check("rstmid host_gnt_rst", host_gnt, 1'b0);
        check("rstmid mem_wren", mem_wren, 1'b0);
        next_cycle();
        rst = 0;
        @(negedge clk);
        check("post_rst i2c_gnt", i2c_gnt, 1'b1);
        check("post_rst host_rvalid", host_rvalid, 1'b0);
        check("post_rst host_rdata", host_rdata, 8'h00);
        check("post_rst i2c_rdata", i2c_rdata, 8'h00);
        next_cycle();
        @(negedge clk);
        check("post_rst rr host_gnt", host_gnt, 1'b1);
        check("post_rst i2c_rvalid", i2c_rvalid, 1'b1);
        check("post_rst i2c_rdata_val", i2c_rdata, 8'hA5);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
